// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between the AHB-side
// controller path (port 0, fixed priority, zero-bubble) and a secondary
// master (port 1, protected by an anti-starvation forced grant). It also
// steers SRAM read data back to the port that issued each read.
// Optional feature macro: SRAM_ARB_LOCK_EN adds lock0/lock1 so the current
// owner can keep the port across consecutive commands.
//
// Handshake: reqN is a valid that stays high with its fields stable until
// gntN. gntN is the ready; it is combinational in the same cycle, and a
// command transfers on every cycle with reqN & gntN. rvalidN is a one-cycle
// pulse with no back-pressure, and rdata is meaningful only while rvalid0 or
// rvalid1 is high.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [2:0]        size0,
    input  logic [2:0]        size1,
`ifdef SRAM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              ram_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ADDR_W-1:0] ram_byte_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [2:0]        ram_size,
    output logic              ram_wen,
    output logic              ram_ren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state,
    output logic [3:0]        dbg_starve
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN0   = 2'd1,
        OWN1   = 2'd2,
        FORCE1 = 2'd3
    } state_t;

    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    state_t              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic                g0, g1;
    logic                hold0, hold1;
    logic [ADDR_W-1:0]   addr_q, addr_sel;
    logic [DATA_W-1:0]   wdata_q, wdata_sel;
    logic [2:0]          size_q, size_sel;
    logic [READ_LAT-1:0] tag_vld_q, tag_own_q;

`ifdef SRAM_ARB_LOCK_EN
    // Owner survives ram_wait cycles so a lock is not lost while the SRAM is busy.
    logic own_vld_q, own_id_q;
    assign hold0 = own_vld_q & ~own_id_q & lock0 & req0;
    assign hold1 = own_vld_q &  own_id_q & lock1 & req1;
`else
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    // Grant decision: ram_wait blocks everything, a held lock wins, then a
    // pending forced grant for port 1, then port 0 priority, then port 1.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (HRESET || ram_wait) begin
            g0 = 1'b0;
        end else if (hold1) begin
            g1 = 1'b1;
        end else if (hold0) begin
            g0 = 1'b1;
        end else if (state_q == FORCE1 && req1) begin
            g1 = 1'b1;
        end else if (req0) begin
            g0 = 1'b1;
        end else if (req1) begin
            g1 = 1'b1;
        end
    end

    // Starvation count and next state; the count saturates so a deferred
    // forced grant keeps re-selecting FORCE1 instead of wrapping.
    always_comb begin
        starve_d = starve_q;
        if (!req1 || g1) begin
            starve_d = '0;
        end else if (!ram_wait && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
        state_d = IDLE;
        if (g1) begin
            state_d = OWN1;
        end else if (g0) begin
            state_d = (req1 && starve_d == STARVE_LIM) ? FORCE1 : OWN0;
        end else if (ram_wait && req1 && state_q == FORCE1) begin
            state_d = FORCE1;
        end
    end

    // Arbiter state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            starve_q <= '0;
`ifdef SRAM_ARB_LOCK_EN
            own_vld_q <= 1'b0;
            own_id_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
`ifdef SRAM_ARB_LOCK_EN
            if (g0 || g1) begin
                own_vld_q <= 1'b1;
                own_id_q  <= g1;
            end else if (!ram_wait) begin
                own_vld_q <= 1'b0;
            end
`endif
        end
    end

    // Command mux: the granted port drives the SRAM fields, otherwise the
    // last issued command's fields are held.
    always_comb begin
        addr_sel  = addr_q;
        wdata_sel = wdata_q;
        size_sel  = size_q;
        if (g0) begin
            addr_sel  = addr0;
            wdata_sel = wdata0;
            size_sel  = size0;
        end else if (g1) begin
            addr_sel  = addr1;
            wdata_sel = wdata1;
            size_sel  = size1;
        end
    end

    // Hold registers for the SRAM address/data/size between commands.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
        end else if (g0 || g1) begin
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            size_q  <= size_sel;
        end
    end

    // Read tag pipeline: {valid, owner} per issued read, advancing every cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            tag_vld_q[0] <= ram_ren;
            tag_own_q[0] <= g1;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    assign gnt0          = g0;
    assign gnt1          = g1;
    assign stall0        = req0 & ~g0 & ~HRESET;
    assign ram_wen       = (g0 & we0) | (g1 & we1);
    assign ram_ren       = (g0 & ~we0) | (g1 & ~we1);
    assign ram_byte_addr = addr_sel;
    assign ram_addr      = addr_sel & WORD_MASK;
    assign ram_wdata     = wdata_sel;
    assign ram_size      = size_sel;
    assign rvalid0       = ~HRESET & tag_vld_q[READ_LAT-1] & ~tag_own_q[READ_LAT-1];
    assign rvalid1       = ~HRESET & tag_vld_q[READ_LAT-1] &  tag_own_q[READ_LAT-1];
    assign rdata         = (rvalid0 | rvalid1) ? ram_rdata : '0;
    assign dbg_state     = state_q;
    assign dbg_starve    = starve_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one instance with READ_LAT=1 (command and
// read checks) and one with READ_LAT=2 (read-return checks), both fed the
// same port commands and each backed by a small SRAM model.
module tb_sram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 5 + AW + AW + DW + 5;
    localparam int RW = 16 + 2 + DW;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- stimulus signals ----------------
    logic          req0, req1, we0, we1, ram_wait;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [2:0]    size0, size1;
`ifdef SRAM_ARB_LOCK_EN
    logic          lock0, lock1;
`endif

    // ---------------- DUT (READ_LAT=1) ----------------
    logic          gnt0, gnt1, stall0, rvalid0, rvalid1, ram_wen, ram_ren;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr, ram_byte_addr;
    logic [2:0]    ram_size;
    logic [1:0]    dbg_state;
    logic [3:0]    dbg_starve;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .STARVE_MAX(4)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1),
`ifdef SRAM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_wait(ram_wait), .ram_addr(ram_addr), .ram_byte_addr(ram_byte_addr),
        .ram_wdata(ram_wdata), .ram_size(ram_size), .ram_wen(ram_wen), .ram_ren(ram_ren),
        .ram_rdata(ram_rdata), .dbg_state(dbg_state), .dbg_starve(dbg_starve)
    );

    // ---------------- DUT (READ_LAT=2) ----------------
    logic          b_gnt0, b_gnt1, b_stall0, b_rvalid0, b_rvalid1, b_ram_wen, b_ram_ren;
    logic [DW-1:0] b_rdata, b_ram_wdata, b_ram_rdata;
    logic [AW-1:0] b_ram_addr, b_ram_byte_addr;
    logic [2:0]    b_ram_size;
    logic [1:0]    b_dbg_state;
    logic [3:0]    b_dbg_starve;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1),
`ifdef SRAM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(b_gnt0), .gnt1(b_gnt1), .stall0(b_stall0),
        .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata(b_rdata),
        .ram_wait(ram_wait), .ram_addr(b_ram_addr), .ram_byte_addr(b_ram_byte_addr),
        .ram_wdata(b_ram_wdata), .ram_size(b_ram_size), .ram_wen(b_ram_wen), .ram_ren(b_ram_ren),
        .ram_rdata(b_ram_rdata), .dbg_state(b_dbg_state), .dbg_starve(b_dbg_starve)
    );

    // ---------------- SRAM models (latency 1 and 2) ----------------
    logic [DW-1:0] mem [0:63];
    logic [63:0]   written;
    logic [DW-1:0] rd1_q, rd2_s0, rd2_s1;

    function automatic logic [DW-1:0] init_word(input logic [5:0] idx);
        case (idx)
            6'd4:    return 32'hDEADBEEF;
            6'd12:   return 32'h11111111;
            6'd13:   return 32'h22222222;
            6'd14:   return 32'h33333333;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [5:0] idx);
        return written[idx] ? mem[idx] : init_word(idx);
    endfunction

    always @(posedge HCLK) begin
        if (HRESET) written <= '0;
        else if (ram_wen) begin
            mem[ram_addr[7:2]]     <= ram_wdata;
            written[ram_addr[7:2]] <= 1'b1;
        end
        if (ram_ren) rd1_q <= rd_word(ram_addr[7:2]);
        if (b_ram_ren) rd2_s0 <= rd_word(b_ram_addr[7:2]);
        rd2_s1 <= rd2_s0;
    end
    assign ram_rdata   = rd1_q;
    assign b_ram_rdata = rd2_s1;

    // ---------------- scoreboard ----------------
    logic [CW-1:0] exp_q[$];
    logic [RW-1:0] rq1[$];
    logic [RW-1:0] rq2[$];
    int n_vec = 0;
    int n_err = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    // Push the expected command-side outputs for the inputs now applied,
    // plus read returns, then advance one cycle. starve < 0 = don't care.
    task automatic step(input logic g0, input logic g1, input logic st0,
                        input logic wen, input logic ren,
                        input logic [AW-1:0] a, input logic [AW-1:0] ba,
                        input logic [DW-1:0] wd, input int starve,
                        input logic [DW-1:0] rd);
        exp_q.push_back({g0, g1, st0, wen, ren, a, ba, wd, (starve >= 0), 4'(starve)});
        if (ren) begin
            rq1.push_back({16'(cyc + 1), g1, g0, rd});
            rq2.push_back({16'(cyc + 2), g1, g0, rd});
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; ram_wait = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; size0 = 3'd2; size1 = 3'd2;
`ifdef SRAM_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [CW-1:0] e_c, a_c;
        logic [RW-1:0] e_r, a_r;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                rq1.delete();
                rq2.delete();
            end
            if (exp_q.size() != 0) begin
                e_c = exp_q.pop_front();
                a_c = {gnt0, gnt1, stall0, ram_wen, ram_ren, ram_addr, ram_byte_addr,
                       ram_wdata, e_c[4], (e_c[4] ? dbg_starve : e_c[3:0])};
                n_vec++;
                if (a_c !== e_c) begin
                    n_err++;
                    $display("FAIL cmd cyc=%0d got=%h exp=%h", cyc, a_c, e_c);
                end
            end
            if (rvalid0 || rvalid1) begin
                a_r = {cyc[15:0], rvalid1, rvalid0, rdata};
                n_vec++;
                if (rq1.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_lat1 unexpected cyc=%0d got=%h exp=none", cyc, a_r);
                end else begin
                    e_r = rq1.pop_front();
                    if (a_r !== e_r) begin
                        n_err++;
                        $display("FAIL rd_lat1 cyc=%0d got=%h exp=%h", cyc, a_r, e_r);
                    end
                end
            end
            if (b_rvalid0 || b_rvalid1) begin
                a_r = {cyc[15:0], b_rvalid1, b_rvalid0, b_rdata};
                n_vec++;
                if (rq2.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_lat2 unexpected cyc=%0d got=%h exp=none", cyc, a_r);
                end else begin
                    e_r = rq2.pop_front();
                    if (a_r !== e_r) begin
                        n_err++;
                        $display("FAIL rd_lat2 cyc=%0d got=%h exp=%h", cyc, a_r, e_r);
                    end
                end
            end
            if (end_req && !end_ack) begin
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL cmd_left got=%0d exp=0", exp_q.size());
                end
                n_vec++;
                if (rq1.size() != 0) begin
                    n_err++;
                    $display("FAIL rd_lat1_missing got=%0d exp=0", rq1.size());
                end
                n_vec++;
                if (rq2.size() != 0) begin
                    n_err++;
                    $display("FAIL rd_lat2_missing got=%0d exp=0", rq2.size());
                end
                end_ack = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : driver
        logic f;
        HRESET = 1'b1;
        idle_inputs();
        @(posedge HCLK);
        #1;
        // reset state: everything low
        step(0, 0, 0, 0, 0, 'h0, 'h0, 'h0, 0, 'h0);
        step(0, 0, 0, 0, 0, 'h0, 'h0, 'h0, 0, 'h0);
        HRESET = 1'b0;

        // single port-0 read, then an unaligned byte address
        req0 = 1; addr0 = 'h10;
        step(1, 0, 0, 0, 1, 'h10, 'h10, 'h0, 0, 'hDEADBEEF);
        req0 = 0;
        step(0, 0, 0, 0, 0, 'h10, 'h10, 'h0, 0, 'h0);
        step(0, 0, 0, 0, 0, 'h10, 'h10, 'h0, 0, 'h0);
        req0 = 1; addr0 = 'h13; size0 = 3'd0;
        step(1, 0, 0, 0, 1, 'h10, 'h13, 'h0, 0, 'hDEADBEEF);
        req0 = 0;
        step(0, 0, 0, 0, 0, 'h10, 'h13, 'h0, 0, 'h0);
        step(0, 0, 0, 0, 0, 'h10, 'h13, 'h0, 0, 'h0);

        // both ports writing for 10 cycles: forced port-1 grant on 4 and 9
        req0 = 1; we0 = 1; addr0 = 'h40; wdata0 = 'hA0A0A0A0; size0 = 3'd2;
        req1 = 1; we1 = 1; addr1 = 'h44; wdata1 = 'hB1B1B1B1;
        for (int i = 0; i < 10; i++) begin
            f = (i == 4) || (i == 9);
            step(!f, f, f, 1, 0, f ? 'h44 : 'h40, f ? 'h44 : 'h40,
                 f ? 'hB1B1B1B1 : 'hA0A0A0A0, (i < 5) ? i : i - 5, 'h0);
        end
        req0 = 0; req1 = 0;
        step(0, 0, 0, 0, 0, 'h44, 'h44, 'hB1B1B1B1, 0, 'h0);

        // port-0 byte write then port-1 read of the same word
        req0 = 1; we0 = 1; addr0 = 'h20; wdata0 = 'hAA; size0 = 3'd0;
        step(1, 0, 0, 1, 0, 'h20, 'h20, 'hAA, 0, 'h0);
        req0 = 0; req1 = 1; we1 = 0; addr1 = 'h20; wdata1 = 'h0;
        step(0, 1, 0, 0, 1, 'h20, 'h20, 'h0, 0, 'hAA);
        req1 = 0;
        step(0, 0, 0, 0, 0, 'h20, 'h20, 'h0, 0, 'h0);
        step(0, 0, 0, 0, 0, 'h20, 'h20, 'h0, 0, 'h0);

        // ram_wait with both requesting: counter holds, port 0 resumes;
        // then a pending forced grant survives a wait cycle
        req0 = 1; we0 = 1; addr0 = 'h40; wdata0 = 'hA0A0A0A0; size0 = 3'd2;
        req1 = 1; we1 = 1; addr1 = 'h44; wdata1 = 'hB1B1B1B1;
        step(1, 0, 0, 1, 0, 'h40, 'h40, 'hA0A0A0A0, 0, 'h0);
        step(1, 0, 0, 1, 0, 'h40, 'h40, 'hA0A0A0A0, 1, 'h0);
        ram_wait = 1;
        repeat (3) step(0, 0, 1, 0, 0, 'h40, 'h40, 'hA0A0A0A0, 2, 'h0);
        ram_wait = 0;
        step(1, 0, 0, 1, 0, 'h40, 'h40, 'hA0A0A0A0, 2, 'h0);
        step(1, 0, 0, 1, 0, 'h40, 'h40, 'hA0A0A0A0, 3, 'h0);
        ram_wait = 1;
        step(0, 0, 1, 0, 0, 'h40, 'h40, 'hA0A0A0A0, 4, 'h0);
        ram_wait = 0;
        step(0, 1, 1, 1, 0, 'h44, 'h44, 'hB1B1B1B1, 4, 'h0);
        req0 = 0; req1 = 0;
        step(0, 0, 0, 0, 0, 'h44, 'h44, 'hB1B1B1B1, 0, 'h0);

        // alternating reads p0,p1,p0; second pass is cut by a reset
        we0 = 0; we1 = 0; wdata0 = 'h0; wdata1 = 'h0;
        for (int pass = 0; pass < 2; pass++) begin
            req0 = 1; addr0 = 'h30;
            step(1, 0, 0, 0, 1, 'h30, 'h30, 'h0, 0, 'h11111111);
            req0 = 0; req1 = 1; addr1 = 'h34;
            step(0, 1, 0, 0, 1, 'h34, 'h34, 'h0, 0, 'h22222222);
            req1 = 0; req0 = 1; addr0 = 'h38;
            step(1, 0, 0, 0, 1, 'h38, 'h38, 'h0, 0, 'h33333333);
            req0 = 0;
            if (pass == 0) begin
                repeat (3) step(0, 0, 0, 0, 0, 'h38, 'h38, 'h0, 0, 'h0);
            end else begin
                HRESET = 1;
                step(0, 0, 0, 0, 0, 'h38, 'h38, 'h0, 0, 'h0);
                HRESET = 0;
                repeat (3) step(0, 0, 0, 0, 0, 'h0, 'h0, 'h0, 0, 'h0);
            end
        end

`ifdef SRAM_ARB_LOCK_EN
        // port 1 owns with lock1 while port 0 waits; release grants port 0 at once
        we0 = 1; we1 = 1;
        req1 = 1; lock1 = 1; addr1 = 'h50; wdata1 = 'h55555555;
        step(0, 1, 0, 1, 0, 'h50, 'h50, 'h55555555, 0, 'h0);
        req0 = 1; addr0 = 'h60; wdata0 = 'h66666666;
        repeat (5) step(0, 1, 1, 1, 0, 'h50, 'h50, 'h55555555, 0, 'h0);
        lock1 = 0;
        step(1, 0, 0, 1, 0, 'h60, 'h60, 'h66666666, 0, 'h0);
        req0 = 0; req1 = 0;
        step(0, 0, 0, 0, 0, 'h60, 'h60, 'h66666666, 1, 'h0);
        step(0, 0, 0, 0, 0, 'h60, 'h60, 'h66666666, 0, 'h0);
`endif

        end_req = 1'b1;
        for (int k = 0; k < 20 && !end_ack; k++) @(posedge HCLK);
        if (!end_ack) begin
            $display("FAIL end_handshake got=timeout exp=ack");
            $fatal(1, "monitor did not finish");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
